dmem_ctrl: RTL and testbench

Multi-cycle data-memory controller for the memory stage of the pipelined processor. It replaces the single-cycle data memory with a handshake to a fixed-latency backing memory. It raises `Stall` so the upstream pipeline registers (exe/mem and earlier) hold while an access is in flight, and it delivers read data to the mem/wb register on a one-cycle `Done`.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_if.sv | 29 ++
 rtl/dmem_lat_cnt.sv | 32 +++
 rtl/dmem_ctrl.sv | 106 ++++++++++
 tb/tb_dmem_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and latency-counter width for the data-memory controller
package dmem_pkg;
   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;
endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - pipeline-side and backing-memory-side signals of the data-memory controller
interface dmem_if;
   logic        Rd;
   logic        Wr;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Dump;
   logic        Stall;
   logic        Done;
   logic [15:0] DataOut;
   logic [15:0] StallCnt;
   logic        err;
   logic [15:0] m_addr;
   logic [15:0] m_din;
   logic        m_rd;
   logic        m_wr;
   logic        m_dump;
   logic [15:0] m_dout;

   modport slave (
      input  Rd, Wr, Addr, DataIn, Dump, m_dout,
      output Stall, Done, DataOut, StallCnt, err, m_addr, m_din, m_rd, m_wr, m_dump
   );

   modport master (
      output Rd, Wr, Addr, DataIn, Dump, m_dout,
      input  Stall, Done, DataOut, StallCnt, err, m_addr, m_din, m_rd, m_wr, m_dump
   );
endinterface

// File: rtl/dmem_lat_cnt.sv
// rtl/dmem_lat_cnt.sv - loadable down-counter that times the backing-memory latency
module dmem_lat_cnt
   import dmem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [LAT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);
endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - multi-cycle data-memory controller: stalls the pipeline across a fixed-latency access
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int LAT       = 4,
   parameter bit ALIGN_CHK = 1'b1
)
(
   input logic   clk,
   input logic   rst,
   dmem_if.slave bus
);
   localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LAT - 1);

   state_t      state_q, state_d;
   logic        is_rd_q, is_rd_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] data_q, data_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        any_req, req_ok, launch, stall;
   logic        cnt_load, cnt_dec, cnt_zero;

   assign any_req = bus.Rd | bus.Wr;
   assign req_ok  = (bus.Rd ^ bus.Wr) && ((ALIGN_CHK == 1'b0) || !bus.Addr[0]);

   dmem_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      is_rd_d  = is_rd_q;
      data_d   = data_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      launch   = 1'b0;
      stall    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_ok) begin
               launch   = 1'b1;
               stall    = 1'b1;
               cnt_load = 1'b1;
               is_rd_d  = bus.Rd;
               state_d  = ACCESS;
            end else begin
               err_d = any_req;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (cnt_zero) begin
               if (is_rd_q) begin
                  data_d = bus.m_dout;
               end
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         // Requests still visible here belong to the access just finished.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         is_rd_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         data_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         is_rd_q     <= is_rd_d;
         done_q      <= done_d;
         err_q       <= err_d;
         data_q      <= data_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Combinational outputs are gated so reset holds them at zero even with live requests.
   assign bus.Stall    = rst & stall;
   assign bus.m_rd     = rst & launch & bus.Rd;
   assign bus.m_wr     = rst & launch & bus.Wr;
   assign bus.m_addr   = rst ? bus.Addr : 16'h0000;
   assign bus.m_din    = rst ? bus.DataIn : 16'h0000;
   assign bus.m_dump   = rst & bus.Dump & (state_q == IDLE) & ~any_req;
   assign bus.Done     = done_q;
   assign bus.err      = err_q;
   assign bus.DataOut  = data_q;
   assign bus.StallCnt = stall_cnt_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl at LAT=4 and LAT=1
module tb_dmem_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;
   logic seen_done;

   always #5 clk = ~clk;

   dmem_if b4 ();
   dmem_if b1 ();

   dmem_ctrl #(.LAT(4), .ALIGN_CHK(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   dmem_ctrl #(.LAT(1), .ALIGN_CHK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   // Backing-memory models: data only valid exactly LAT cycles after m_rd.
   int          age4 = 0;
   int          age1 = 0;
   logic [15:0] a4 = 16'h0000;
   logic [15:0] wr_addr4 = 16'hFFFF;
   logic [15:0] wr_data4 = 16'h0000;

   always @(posedge clk) begin
      if (b4.m_wr) begin
         wr_addr4 <= b4.m_addr;
         wr_data4 <= b4.m_din;
      end
      if (b4.m_rd) begin
         age4 <= 1;
         a4   <= b4.m_addr;
      end else if (age4 != 0) begin
         age4 <= age4 + 1;
      end
      if (b1.m_rd) begin
         age1 <= 1;
      end else if (age1 != 0) begin
         age1 <= age1 + 1;
      end
   end

   assign b4.m_dout = (age4 == 4) ? ((a4 == wr_addr4) ? wr_data4 : 16'hBEEF) : 16'hDEAD;
   assign b1.m_dout = (age1 == 1) ? 16'h5A5A : 16'hDEAD;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      b4.Rd = 1'b0; b4.Wr = 1'b0; b4.Addr = 16'h1234; b4.DataIn = 16'h5678; b4.Dump = 1'b0;
      b1.Rd = 1'b0; b1.Wr = 1'b0; b1.Addr = 16'h0000; b1.DataIn = 16'h0000; b1.Dump = 1'b0;
      #12;
      chk("rst_stall",    16'(b4.Stall),    16'h0);
      chk("rst_done",     16'(b4.Done),     16'h0);
      chk("rst_dataout",  b4.DataOut,       16'h0000);
      chk("rst_stallcnt", b4.StallCnt,      16'h0000);
      chk("rst_err",      16'(b4.err),      16'h0);
      chk("rst_m_addr",   b4.m_addr,        16'h0000);
      chk("rst_m_din",    b4.m_din,         16'h0000);
      next_cycle();
      rst = 1'b1;
      b4.Addr = 16'h0000;
      b4.DataIn = 16'h0000;

      // Read: launch cycle 0, Done cycle 5
      next_cycle();
      b4.Rd = 1'b1; b4.Addr = 16'h0010;
      #1;
      chk("rd_c0_stall", 16'(b4.Stall), 16'h1);
      chk("rd_c0_m_rd",  16'(b4.m_rd),  16'h1);
      chk("rd_c0_addr",  b4.m_addr,     16'h0010);
      for (int c = 1; c <= 4; c++) begin
         next_cycle(); #1;
         chk("rd_stall", 16'(b4.Stall), 16'h1);
         chk("rd_m_rd",  16'(b4.m_rd),  16'h0);
         chk("rd_done",  16'(b4.Done),  16'h0);
      end
      next_cycle(); #1;
      chk("rd_c5_done",    16'(b4.Done),  16'h1);
      chk("rd_c5_stall",   16'(b4.Stall), 16'h0);
      chk("rd_c5_no_rel",  16'(b4.m_rd),  16'h0);
      chk("rd_c5_dataout", b4.DataOut,    16'hBEEF);
      next_cycle();
      b4.Rd = 1'b0;
      #1;
      chk("rd_c6_done",     16'(b4.Done), 16'h0);
      chk("rd_c6_stallcnt", b4.StallCnt,  16'd5);

      // Write then read-back
      do_reset();
      next_cycle();
      b4.Wr = 1'b1; b4.Addr = 16'h0020; b4.DataIn = 16'h1234;
      #1;
      chk("wr_c0_m_wr",  16'(b4.m_wr),  16'h1);
      chk("wr_c0_m_din", b4.m_din,      16'h1234);
      chk("wr_c0_m_rd",  16'(b4.m_rd),  16'h0);
      chk("wr_c0_stall", 16'(b4.Stall), 16'h1);
      for (int c = 1; c <= 4; c++) begin
         next_cycle(); #1;
         chk("wr_m_wr_once", 16'(b4.m_wr), 16'h0);
      end
      next_cycle(); #1;
      chk("wr_c5_done",    16'(b4.Done), 16'h1);
      chk("wr_c5_keep",    b4.DataOut,   16'h0000);
      chk("wr_c5_no_rel",  16'(b4.m_wr), 16'h0);
      next_cycle();
      b4.Wr = 1'b0; b4.Rd = 1'b1;
      #1;
      chk("rb_c6_m_rd",  16'(b4.m_rd), 16'h1);
      chk("rb_c6_addr",  b4.m_addr,    16'h0020);
      for (int c = 7; c <= 10; c++) begin
         next_cycle(); #1;
         chk("rb_stall", 16'(b4.Stall), 16'h1);
      end
      next_cycle(); #1;
      chk("rb_c11_done",     16'(b4.Done), 16'h1);
      chk("rb_c11_dataout",  b4.DataOut,   16'h1234);
      chk("rb_c11_stallcnt", b4.StallCnt,  16'd10);
      next_cycle();
      b4.Rd = 1'b0;

      // Illegal requests
      next_cycle();
      b4.Rd = 1'b1; b4.Wr = 1'b1; b4.Addr = 16'h0020;
      #1;
      chk("ill_both_stall", 16'(b4.Stall), 16'h0);
      chk("ill_both_m_rd",  16'(b4.m_rd),  16'h0);
      chk("ill_both_m_wr",  16'(b4.m_wr),  16'h0);
      chk("ill_both_err0",  16'(b4.err),   16'h0);
      next_cycle();
      b4.Rd = 1'b0; b4.Wr = 1'b0;
      #1;
      chk("ill_both_err", 16'(b4.err), 16'h1);
      next_cycle(); #1;
      chk("ill_err_pulse", 16'(b4.err), 16'h0);
      b4.Rd = 1'b1; b4.Addr = 16'h0011;
      #1;
      chk("ill_odd_stall", 16'(b4.Stall), 16'h0);
      chk("ill_odd_m_rd",  16'(b4.m_rd),  16'h0);
      next_cycle();
      b4.Rd = 1'b0;
      #1;
      chk("ill_odd_err",  16'(b4.err),   16'h1);
      chk("ill_odd_idle", 16'(b4.Stall), 16'h0);

      // Dump interaction
      next_cycle();
      b4.Dump = 1'b1;
      #1;
      chk("dump_idle", 16'(b4.m_dump), 16'h1);
      next_cycle();
      b4.Rd = 1'b1; b4.Addr = 16'h0010;
      #1;
      chk("dump_req_c0",  16'(b4.m_dump), 16'h0);
      chk("dump_req_rd",  16'(b4.m_rd),   16'h1);
      for (int c = 1; c <= 5; c++) begin
         next_cycle(); #1;
         chk("dump_wait", 16'(b4.m_dump), 16'h0);
      end
      next_cycle();
      b4.Rd = 1'b0;
      #1;
      chk("dump_c6", 16'(b4.m_dump), 16'h1);
      next_cycle();
      b4.Dump = 1'b0;

      // Reset in the middle of a read
      next_cycle();
      b4.Rd = 1'b1; b4.Addr = 16'h0010;
      #1;
      chk("mid_c0_stall", 16'(b4.Stall), 16'h1);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      chk("mid_stall",    16'(b4.Stall), 16'h0);
      chk("mid_done",     16'(b4.Done),  16'h0);
      chk("mid_dataout",  b4.DataOut,    16'h0000);
      chk("mid_stallcnt", b4.StallCnt,   16'h0000);
      b4.Rd = 1'b0;
      next_cycle();
      rst = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         next_cycle(); #1;
         seen_done = seen_done | b4.Done;
      end
      chk("mid_no_done", 16'(seen_done), 16'h0);

      // LAT=1 corner
      do_reset();
      next_cycle();
      b1.Rd = 1'b1; b1.Addr = 16'h0040;
      #1;
      chk("l1_c0_stall", 16'(b1.Stall), 16'h1);
      next_cycle(); #1;
      chk("l1_c1_stall", 16'(b1.Stall), 16'h1);
      chk("l1_c1_done",  16'(b1.Done),  16'h0);
      next_cycle(); #1;
      chk("l1_c2_done",     16'(b1.Done),  16'h1);
      chk("l1_c2_stall",    16'(b1.Stall), 16'h0);
      chk("l1_c2_dataout",  b1.DataOut,    16'h5A5A);
      chk("l1_c2_stallcnt", b1.StallCnt,   16'd2);
      next_cycle();
      b1.Rd = 1'b0;
      #1;
      chk("l1_c3_done", 16'(b1.Done), 16'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
